// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the request side and the CDB broadcast side of the Common Data Bus
//   arbiter into one interface.
//
//   Parameters (must match the cdb_arbiter instance this interface feeds):
//     N_FU    number of requesting functional units (2..8)
//     DATA_W  result value width
//     TAG_W   reservation-station tag width (tag 0 means INVALID)
//
//   Signals:
//     flush      squash pending and next-edge broadcasts (branch mispredict)
//     req        per-FU request, held until granted
//     req_tag    packed per-FU tags, FU i at [i*TAG_W +: TAG_W]
//     req_val    packed per-FU results, FU i at [i*DATA_W +: DATA_W]
//     grant      one-hot combinational grant
//     cdb_valid  registered broadcast-present flag
//     cdb_tag    registered broadcast tag (0 when idle)
//     cdb_val    registered broadcast value (0 when idle)
//     rr_ptr     current highest-priority requester (debug/coverage)
//
//   Modports:
//     master  the functional-unit / consumer side
//     slave   the arbiter itself
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int N_FU   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  localparam int PTR_W = $clog2(N_FU);

  logic                     flush;
  logic [N_FU-1:0]          req;
  logic [N_FU*TAG_W-1:0]    req_tag;
  logic [N_FU*DATA_W-1:0]   req_val;
  logic [N_FU-1:0]          grant;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_val;
  logic [PTR_W-1:0]         rr_ptr;

  modport master (
    output flush,
    output req,
    output req_tag,
    output req_val,
    input  grant,
    input  cdb_valid,
    input  cdb_tag,
    input  cdb_val,
    input  rr_ptr
  );

  modport slave (
    input  flush,
    input  req,
    input  req_tag,
    input  req_val,
    output grant,
    output cdb_valid,
    output cdb_tag,
    output cdb_val,
    output rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbiter for the single Common Data Bus of the out-of-order
//   core. Every cycle at most one functional unit is granted; its tag and
//   value are registered and broadcast on the following cycle to the map
//   table, reservation stations and register-file writeback.
//
//   Ports:
//     CLK    core clock, rising edge
//     RST_N  asynchronous, active-low reset
//     bus    cdb_arbiter_if.slave carrying flush, req/req_tag/req_val,
//            grant, cdb_valid/cdb_tag/cdb_val and rr_ptr
//
//   Behaviour summary:
//     - FU i is eligible when req[i]=1 and its tag is non-zero.
//     - Search starts at rr_ptr and wraps N_FU-1 -> 0; first eligible wins.
//     - grant is combinational and is forced to zero by flush or reset.
//     - A grant to FU i moves rr_ptr to (i+1) mod N_FU; otherwise it holds.
//     - Broadcast registers load the winner, or clear when nothing is granted.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_FU   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_FU);

  // N_FU held one bit wider than the pointer so that rr_ptr + offset can be
  // wrapped without overflow, including non-power-of-two N_FU.
  localparam logic [PTR_W:0] N_FU_EXT  = (PTR_W+1)'(N_FU);
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(N_FU - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic               cdb_valid_reg, cdb_valid_next;
  logic [TAG_W-1:0]   cdb_tag_reg,   cdb_tag_next;
  logic [DATA_W-1:0]  cdb_val_reg,   cdb_val_next;
  logic [PTR_W-1:0]   rr_ptr_reg,    rr_ptr_next;

  // ---------------------------------------------------------------------------
  // Per-FU unpacking and eligibility
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]   tag_arr  [N_FU];
  logic [DATA_W-1:0]  val_arr  [N_FU];
  logic [N_FU-1:0]    elig;

  for (genvar gi = 0; gi < N_FU; gi++) begin : g_unpack
    assign tag_arr[gi] = bus.req_tag[gi*TAG_W +: TAG_W];
    assign val_arr[gi] = bus.req_val[gi*DATA_W +: DATA_W];
    // A zero tag is INVALID: such a request is simply never selected.
    assign elig[gi]    = bus.req[gi] && (tag_arr[gi] != '0);
  end

  // ---------------------------------------------------------------------------
  // Rotated search order: cand_idx[k] is the FU examined k-th this cycle.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]   cand_idx [N_FU];

  for (genvar gi = 0; gi < N_FU; gi++) begin : g_cand
    logic [PTR_W:0] sum;
    assign sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
    assign cand_idx[gi] = (sum >= N_FU_EXT) ? PTR_W'(sum - N_FU_EXT)
                                            : sum[PTR_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Priority pick over the rotated order
  // ---------------------------------------------------------------------------
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic               grant_ok;
  logic [N_FU-1:0]    grant_c;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_FU; k++) begin
      if (!win_found && elig[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // Reset is folded in so grant stays low for the whole time RST_N is low,
  // not just until the next edge.
  assign grant_ok = win_found && !bus.flush && RST_N;

  always_comb begin
    grant_c = '0;
    if (grant_ok) begin
      grant_c[win_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: broadcast pipeline and pointer advance
  // ---------------------------------------------------------------------------
  always_comb begin
    cdb_valid_next = 1'b0;
    cdb_tag_next   = '0;
    cdb_val_next   = '0;
    rr_ptr_next    = rr_ptr_reg;
    if (grant_ok) begin
      cdb_valid_next = 1'b1;
      cdb_tag_next   = tag_arr[win_idx];
      cdb_val_next   = val_arr[win_idx];
      // Explicit wrap so non-power-of-two N_FU returns to 0 after N_FU-1.
      rr_ptr_next    = (win_idx == LAST_FU) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_val_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      cdb_valid_reg <= cdb_valid_next;
      cdb_tag_reg   <= cdb_tag_next;
      cdb_val_reg   <= cdb_val_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.grant     = grant_c;
  assign bus.cdb_valid = cdb_valid_reg;
  assign bus.cdb_tag   = cdb_tag_reg;
  assign bus.cdb_val   = cdb_val_reg;
  assign bus.rr_ptr    = rr_ptr_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed-vector bench for cdb_arbiter (N_FU=4, DATA_W=32, TAG_W=4).
//   Inputs are driven 1 time unit after the rising edge; outputs are
//   checked on the falling edge (or mid-cycle for the asynchronous reset).
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N_FU   = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic CLK;
  logic RST_N;

  int errors = 0;
  int checks = 0;

  cdb_arbiter_if #(.N_FU(N_FU), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.N_FU(N_FU), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] v);
    bus.req_tag[i*TAG_W +: TAG_W]    = t;
    bus.req_val[i*DATA_W +: DATA_W]  = v;
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [N_FU-1:0] exp_grant;

    // ---------------- Reset then idle ----------------
    RST_N     = 1'b0;
    bus.flush = 1'b0;
    bus.req   = 4'b1111;
    for (int i = 0; i < N_FU; i++) set_fu(i, TAG_W'(i + 1), 32'h0);
    @(negedge CLK);
    check_val("rst_grant", bus.grant, 4'b0000);
    check_val("rst_valid", bus.cdb_valid, 1'b0);
    check_val("rst_rrptr", bus.rr_ptr, 2'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N   = 1'b1;
    bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check_val("idle_valid", bus.cdb_valid, 1'b0);
      check_val("idle_tag",   bus.cdb_tag,   4'd0);
      check_val("idle_rrptr", bus.rr_ptr,    2'd0);
      check_val("idle_grant", bus.grant,     4'b0000);
      next_cyc();
    end
    $display("txn idle: reset released, bus quiet");

    // ---------------- Round-robin fairness ----------------
    for (int i = 0; i < N_FU; i++) set_fu(i, TAG_W'(i + 1), 32'hA000_0000 + 32'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      exp_grant = 4'(1 << (k % 4));
      check_val("rr_grant", bus.grant, exp_grant);
      if (k > 0) begin
        check_val("rr_valid", bus.cdb_valid, 1'b1);
        check_val("rr_tag",   bus.cdb_tag,   4'((k - 1) % 4 + 1));
      end
      next_cyc();
    end
    bus.req = '0;
    @(negedge CLK);
    check_val("rr_last_tag", bus.cdb_tag, 4'd4);
    check_val("rr_last_val", bus.cdb_val, 32'hA000_0003);
    check_val("rr_end_ptr",  bus.rr_ptr,  2'd0);
    check_val("rr_idle_grant", bus.grant, 4'b0000);
    $display("txn round_robin: 8 grants issued");
    next_cyc();

    // ---------------- Single requester ----------------
    set_fu(2, 4'd5, 32'hDEAD_BEEF);
    bus.req = 4'b0100;
    @(negedge CLK);
    check_val("single_grant", bus.grant, 4'b0100);
    next_cyc();
    bus.req = '0;
    @(negedge CLK);
    check_val("single_valid", bus.cdb_valid, 1'b1);
    check_val("single_tag",   bus.cdb_tag,   4'd5);
    check_val("single_val",   bus.cdb_val,   32'hDEAD_BEEF);
    check_val("single_rrptr", bus.rr_ptr,    2'd3);
    $display("txn single: FU2 tag=5 broadcast");
    next_cyc();

    // ---------------- Invalid tag ----------------
    set_fu(0, 4'd0, 32'h1111_1111);
    set_fu(1, 4'd7, 32'h7777_7777);
    bus.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_val("inv_grant", bus.grant, 4'b0010);
      if (k > 0) begin
        check_val("inv_tag", bus.cdb_tag, 4'd7);
        check_val("inv_val", bus.cdb_val, 32'h7777_7777);
      end
      next_cyc();
    end
    bus.req = '0;
    @(negedge CLK);
    check_val("inv_rrptr", bus.rr_ptr, 2'd2);
    $display("txn invalid_tag: FU0 tag 0 never granted");
    next_cyc();

    // ---------------- Flush ----------------
    set_fu(0, 4'd9, 32'h9999_0000);
    bus.req = 4'b0001;
    @(negedge CLK);
    check_val("fl_t_grant", bus.grant, 4'b0001);
    next_cyc();
    set_fu(1, 4'd3, 32'h3333_0000);
    bus.req   = 4'b0010;
    bus.flush = 1'b1;
    @(negedge CLK);
    check_val("fl_t1_valid", bus.cdb_valid, 1'b1);
    check_val("fl_t1_tag",   bus.cdb_tag,   4'd9);
    check_val("fl_t1_grant", bus.grant,     4'b0000);
    check_val("fl_t1_rrptr", bus.rr_ptr,    2'd1);
    next_cyc();
    bus.flush = 1'b0;
    bus.req   = '0;
    @(negedge CLK);
    check_val("fl_t2_valid", bus.cdb_valid, 1'b0);
    check_val("fl_t2_tag",   bus.cdb_tag,   4'd0);
    check_val("fl_t2_rrptr", bus.rr_ptr,    2'd1);
    next_cyc();
    // Flush with every requester eligible still grants nobody.
    for (int i = 0; i < N_FU; i++) set_fu(i, TAG_W'(i + 1), 32'h0);
    bus.req   = 4'b1111;
    bus.flush = 1'b1;
    @(negedge CLK);
    check_val("fl_all_grant", bus.grant, 4'b0000);
    next_cyc();
    bus.flush = 1'b0;
    bus.req   = '0;
    @(negedge CLK);
    check_val("fl_all_valid", bus.cdb_valid, 1'b0);
    check_val("fl_all_rrptr", bus.rr_ptr,    2'd1);
    $display("txn flush: tag 9 completed, follow-on squashed");
    next_cyc();

    // ---------------- Asynchronous reset mid-stream ----------------
    set_fu(2, 4'd6, 32'h1234_5678);
    bus.req = 4'b0100;
    next_cyc();
    check_val("ar_pre_valid", bus.cdb_valid, 1'b1);
    check_val("ar_pre_tag",   bus.cdb_tag,   4'd6);
    check_val("ar_pre_rrptr", bus.rr_ptr,    2'd3);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("ar_valid", bus.cdb_valid, 1'b0);
    check_val("ar_tag",   bus.cdb_tag,   4'd0);
    check_val("ar_val",   bus.cdb_val,   32'h0);
    check_val("ar_rrptr", bus.rr_ptr,    2'd0);
    check_val("ar_grant", bus.grant,     4'b0000);
    bus.req = '0;
    next_cyc();
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("ar_post_valid", bus.cdb_valid, 1'b0);
    check_val("ar_post_rrptr", bus.rr_ptr,    2'd0);
    $display("txn async_reset: broadcast dropped between edges");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single Common Data Bus (CDB) among the functional units of the out-of-order core.
- Functional units are ALU, branch, multiply/divide and load/store. Each unit requests the CDB to broadcast a completed result as a reservation-station tag plus a 32-bit value.
- Each cycle the block grants one requester, round-robin, and drives a registered CDB broadcast.
- The broadcast is consumed by the map table, the reservation stations and the register-file writeback.

Parameters:
- N_FU, 4, number of requesting functional units (2..8).
- DATA_W, 32, result value width.
- TAG_W, 4, reservation-station tag width. Tag value 0 is INVALID.

Ports:
- CLK  input  1  core clock, rising-edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous squash of all pending and in-flight broadcasts (branch mispredict).
- req  input  N_FU  per-FU request; bit i held high until grant[i].
- req_tag  input  N_FU*TAG_W  per-FU tag; FU i occupies bits [i*TAG_W +: TAG_W].
- req_val  input  N_FU*DATA_W  per-FU result; FU i occupies bits [i*DATA_W +: DATA_W].
- grant  output  N_FU  one-hot combinational grant, same cycle as the winning request.
- cdb_valid  output  1  registered; broadcast present this cycle.
- cdb_tag  output  TAG_W  registered broadcast tag; INVALID (0) when cdb_valid=0.
- cdb_val  output  DATA_W  registered broadcast value; 0 when cdb_valid=0.
- rr_ptr  output  $clog2(N_FU)  current highest-priority requester, for debug and coverage.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_val=0, rr_ptr=0.
  - grant=0 while RST_N is low.
  - Reset mid-broadcast drops the broadcast immediately; there is no replay.
- Eligibility:
  - Requester i is eligible iff req[i]=1 and its tag != 0.
  - A request carrying tag 0 is never granted. The FU keeps holding it; it is not an error condition for this block.
- Arbitration (combinational):
  - Search starts at rr_ptr and wraps from N_FU-1 to 0.
  - The first eligible requester wins; grant is one-hot or all-zero.
  - When flush=1, grant=0.
- Pointer update:
  - On a clock edge with a grant to i, rr_ptr <= (i+1) mod N_FU.
  - With no grant, rr_ptr holds.
  - Fairness: a continuously eligible requester is granted within N_FU cycles.
- Broadcast pipeline (1-cycle latency):
  - On the edge where grant[i]=1: cdb_valid<=1, cdb_tag<=req_tag[i], cdb_val<=req_val[i].
  - With no grant: cdb_valid<=0, cdb_tag<=0, cdb_val<=0.
  - Back-to-back broadcasts every cycle are supported with no bubble.
- Handshake:
  - The FU samples grant[i] in the same cycle.
  - The FU must drop req[i], or present its next result, on the following cycle.
  - Req/tag/val must be stable while req is high and ungranted. This block does not check it.
- Flush:
  - flush=1 suppresses the grant that cycle, and the next-edge broadcast is cleared (cdb_valid<=0).
  - A broadcast already registered (cdb_valid=1 during the flush cycle) still completes that cycle.
  - rr_ptr is unchanged by flush.
- Simultaneous events:
  - flush with all requests high gives no grant.
  - A single requester is granted every cycle it requests.
  - A requester that is also the rr_ptr target wins.
- Width rules:
  - rr_ptr wraps modulo N_FU, including non-power-of-two N_FU (e.g. N_FU=3: 2 -> 0).

Test Plan:
- Reset then idle: RST_N low for 2 cycles, release, req=0 -> cdb_valid=0, cdb_tag=0, rr_ptr=0, grant=0 every cycle.
- Single requester:
  - Stimulus: req=4'b0100, tag=5, val=32'hDEADBEEF held for 1 cycle.
  - Response: grant=4'b0100 the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_val=32'hDEADBEEF; rr_ptr=3.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held for 8 cycles, tags 1..4 on FU0..FU3.
  - Response: grant sequence 0001,0010,0100,1000,0001,...; cdb_tag sequence 1,2,3,4,1,... with one-cycle lag.
- Invalid tag:
  - Stimulus: req=4'b0011, FU0 tag=0, FU1 tag=7.
  - Response: grant=4'b0010 every cycle; FU0 is never granted; cdb_tag=7.
- Flush:
  - Stimulus: req=4'b0001 (tag 9) granted at cycle t; flush=1 at t+1 with req=4'b0010 (tag 3).
  - Response: cdb_valid=1, cdb_tag=9 at t+1; grant=0 at t+1; cdb_valid=0 at t+2; rr_ptr=1 throughout t+1..t+2.
- Async reset mid-stream:
  - Stimulus: assert RST_N=0 between clock edges while cdb_valid=1.
  - Response: cdb_valid=0, cdb_tag=0 and rr_ptr=0 immediately, without waiting for CLK.
